// File: rtl/piano_gfx_pkg.sv
// piano_gfx_pkg: shared colours, default geometry, FSM states and address-width helper
package piano_gfx_pkg;

    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_WHITE  = 3'b111;
    localparam logic [2:0] COL_PRESS  = 3'b001;
    localparam logic [2:0] COL_PROMPT = 3'b100;

    localparam int DEF_WIDTH    = 160;
    localparam int DEF_HEIGHT   = 120;
    localparam int DEF_NUM_KEYS = 24;
    localparam int DEF_KEY_X0   = 8;
    localparam int DEF_KEY_Y0   = 40;
    localparam int DEF_KEY_W    = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FLUSH
    } scan_state_t;

    function automatic int addr_w(input int w, input int h);
        return $clog2(w * h);
    endfunction

endpackage

// File: rtl/piano_frame_scanner_key_hit_decoder.sv
// key_hit_decoder: follows the S0 x counter with column/key counters (no divider) and registers {hit, key_idx} into S1
module key_hit_decoder
    import piano_gfx_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int KEY_X0   = DEF_KEY_X0,
    parameter int KEY_Y0   = DEF_KEY_Y0,
    parameter int KEY_W    = DEF_KEY_W
) (
    input  logic                          CLOCK_50,
    input  logic                          resetn,
    input  logic                          clear,
    input  logic                          step,
    input  logic [$clog2(WIDTH)-1:0]      x,
    input  logic [$clog2(HEIGHT)-1:0]     y,
    output logic                          hit,
    output logic [$clog2(NUM_KEYS)-1:0]   key_idx
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int KW = $clog2(NUM_KEYS);
    localparam int IW = $clog2(NUM_KEYS + 1);
    localparam int CW = $clog2(KEY_W + 1);
    localparam logic [XW-1:0] X0       = XW'(KEY_X0);
    localparam logic [XW-1:0] X_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y0       = YW'(KEY_Y0);
    localparam logic [IW-1:0] IDX_END  = IW'(NUM_KEYS);
    localparam logic [CW-1:0] COL_LAST = CW'(KEY_W - 1);

    logic [CW-1:0] col;
    logic [IW-1:0] idx;
    logic          in_keys;

    assign in_keys = (x >= X0) && (idx != IDX_END);

    // column and key index of the pixel currently in S0; restart at each line and frame
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            col <= '0;
            idx <= '0;
        end else if (clear || (step && x == X_LAST)) begin
            col <= '0;
            idx <= '0;
        end else if (step && in_keys) begin
            col <= (col == COL_LAST) ? '0 : col + 1'b1;
            idx <= (col == COL_LAST) ? idx + 1'b1 : idx;
        end
    end

    // hand the decode to S1 alongside the ROM read
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            hit     <= 1'b0;
            key_idx <= '0;
        end else begin
            hit     <= in_keys && (y >= Y0);
            key_idx <= idx[KW-1:0];
        end
    end

endmodule

// File: rtl/piano_frame_scanner.sv
// piano_frame_scanner: raster-scans the keyboard ROM image and overlays pressed keys for vga_adapter;
// optional prompt-key highlight when PIANO_SCAN_PROMPT_EN is defined
module piano_frame_scanner
    import piano_gfx_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int COLOUR_W = 3,
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int KEY_X0   = DEF_KEY_X0,
    parameter int KEY_Y0   = DEF_KEY_Y0,
    parameter int KEY_W    = DEF_KEY_W,
    parameter logic [COLOUR_W-1:0] PRESS_COLOUR = COL_PRESS,
    parameter logic [COLOUR_W-1:0] OUTLINE_COL  = COL_BLACK
`ifdef PIANO_SCAN_PROMPT_EN
    , parameter logic [COLOUR_W-1:0] PROMPT_COLOUR = COL_PROMPT
`endif
) (
    input  logic                               CLOCK_50,
    input  logic                               resetn,
    input  logic [NUM_KEYS-1:0]                key_mask,
    input  logic                               frame_req,
`ifdef PIANO_SCAN_PROMPT_EN
    input  logic                               prompt_valid,
    input  logic [$clog2(NUM_KEYS)-1:0]        prompt_key,
`endif
    output logic [addr_w(WIDTH, HEIGHT)-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0]                rom_data,
    output logic [$clog2(WIDTH)-1:0]           x,
    output logic [$clog2(HEIGHT)-1:0]          y,
    output logic [COLOUR_W-1:0]                colour,
    output logic                               plot,
    output logic                               busy,
    output logic                               frame_done
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int KW = $clog2(NUM_KEYS);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    scan_state_t         state, state_n;
    logic [XW-1:0]       sx, x1;
    logic [YW-1:0]       sy, y1;
    logic [NUM_KEYS-1:0] mask_snap;
    logic [KW-1:0]       idx1;
    logic [COLOUR_W-1:0] pix_col;
    logic                pending, flush_cnt, start, last_pix, change, v1, hit1, pressed;

`ifdef PIANO_SCAN_PROMPT_EN
    logic          pv_snap, prompted;
    logic [KW-1:0] pk_snap;
    assign change   = (key_mask != mask_snap) || (prompt_valid != pv_snap) ||
                      (prompt_valid && prompt_key != pk_snap);
    assign prompted = hit1 && pv_snap && (idx1 == pk_snap) && (rom_data != OUTLINE_COL);
`else
    assign change   = key_mask != mask_snap;
`endif

    assign last_pix = (sx == X_LAST) && (sy == Y_LAST);
    assign busy     = state != S_IDLE;
    assign pressed  = hit1 && mask_snap[idx1] && (rom_data != OUTLINE_COL);

`ifdef PIANO_SCAN_PROMPT_EN
    assign pix_col = pressed ? PRESS_COLOUR : prompted ? PROMPT_COLOUR : rom_data;
`else
    assign pix_col = pressed ? PRESS_COLOUR : rom_data;
`endif

    // frame state register
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // next state: start on any pending redraw, drain two pipeline cycles after the last pixel
    always_comb begin
        start   = (state == S_IDLE) && (pending || frame_req || change);
        state_n = state;
        if (start)
            state_n = S_SCAN;
        else if (state == S_SCAN && last_pix)
            state_n = S_FLUSH;
        else if (state == S_FLUSH && flush_cnt)
            state_n = S_IDLE;
    end

    // S0: scan counters, ROM address, snapshots and the collapsed redraw request
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sx        <= '0;
            sy        <= '0;
            rom_addr  <= '0;
            mask_snap <= '0;
            pending   <= 1'b1;
            flush_cnt <= 1'b0;
`ifdef PIANO_SCAN_PROMPT_EN
            pv_snap   <= 1'b0;
            pk_snap   <= '0;
`endif
        end else begin
            if (start) begin
                sx        <= '0;
                sy        <= '0;
                rom_addr  <= '0;
                mask_snap <= key_mask;
                pending   <= 1'b0;
`ifdef PIANO_SCAN_PROMPT_EN
                pv_snap   <= prompt_valid;
                pk_snap   <= prompt_key;
`endif
            end else begin
                if (state != S_IDLE && (frame_req || change))
                    pending <= 1'b1;
                if (state == S_SCAN && !last_pix) begin
                    sx       <= (sx == X_LAST) ? '0 : sx + 1'b1;
                    sy       <= (sx == X_LAST) ? sy + 1'b1 : sy;
                    rom_addr <= rom_addr + 1'b1;
                end
            end
            flush_cnt <= (state == S_FLUSH) ? !flush_cnt : 1'b0;
        end
    end

    // S1: coordinates travel with the ROM read
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            v1 <= 1'b0;
            x1 <= '0;
            y1 <= '0;
        end else begin
            v1 <= state == S_SCAN;
            x1 <= sx;
            y1 <= sy;
        end
    end

    // S2: registered pixel towards vga_adapter and end-of-frame pulse
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            x          <= x1;
            y          <= y1;
            colour     <= pix_col;
            plot       <= v1;
            frame_done <= (state == S_FLUSH) && flush_cnt;
        end
    end

    key_hit_decoder #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .NUM_KEYS(NUM_KEYS),
        .KEY_X0(KEY_X0), .KEY_Y0(KEY_Y0), .KEY_W(KEY_W)
    ) u_hit (
        .CLOCK_50(CLOCK_50),
        .resetn(resetn),
        .clear(start),
        .step(state == S_SCAN),
        .x(sx),
        .y(sy),
        .hit(hit1),
        .key_idx(idx1)
    );

endmodule
